// File: rtl/hacd_pkg.sv
// Shared types for the hawk CPU-side lookup path.
//   cpu_reqpkt_t        : lookup request from a CPU stall block
//   hawk_cpu_ovrd_pkt_t : translated page plus the release pulse back to it
//   lkup_req_t          : request issued to the hawk lookup engine
//   hawk_lkup_arb_state_e, GNT_RD/GNT_WR : arbiter FSM and grant encoding
`ifndef HACD_AXI4_ADDR_WIDTH
`define HACD_AXI4_ADDR_WIDTH 32
`endif

package hacd_pkg;

    // 4KB page number width
    localparam int PPA_WIDTH = `HACD_AXI4_ADDR_WIDTH - 12;

    typedef struct packed {
        logic [PPA_WIDTH-1:0] hppa;
        logic                 valid;
        logic                 zeroBlkWr;
    } cpu_reqpkt_t;

    typedef struct packed {
        logic [PPA_WIDTH-1:0] ppa;
        logic                 allow_access;
    } hawk_cpu_ovrd_pkt_t;

    typedef struct packed {
        logic [PPA_WIDTH-1:0] hppa;
        logic                 is_wr;
        logic                 zeroBlkWr;
    } lkup_req_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_REQ,
        ST_WAIT_RSP,
        ST_RELEASE
    } hawk_lkup_arb_state_e;

    // Grant side encoding; also the index into the 2-bit request vector
    localparam logic GNT_RD = 1'b0;
    localparam logic GNT_WR = 1'b1;

endpackage

// File: rtl/hawk_cpu_lkup_arb_if.sv
// Lookup channel between the CPU lookup arbiter and the hawk engine.
//   lkup_req / lkup_req_valid / lkup_req_ready : request handshake
//   lkup_rsp_valid / lkup_rsp_ppa              : single-cycle response
// master = arbiter side, slave = hawk side.
interface hawk_cpu_lkup_arb_if;
    import hacd_pkg::*;

    lkup_req_t            lkup_req;
    logic                 lkup_req_valid;
    logic                 lkup_req_ready;
    logic                 lkup_rsp_valid;
    logic [PPA_WIDTH-1:0] lkup_rsp_ppa;

    modport master (
        output lkup_req, lkup_req_valid,
        input  lkup_req_ready, lkup_rsp_valid, lkup_rsp_ppa
    );

    modport slave (
        input  lkup_req, lkup_req_valid,
        output lkup_req_ready, lkup_rsp_valid, lkup_rsp_ppa
    );
endinterface

// File: rtl/hawk_rr_arb2.sv
// Two-requester round-robin arbiter.
//   clk, rst_n : clock, async active-low reset
//   en         : grant enable; last_grant only moves on an enabled grant
//   req[1:0]   : requests indexed by GNT_RD / GNT_WR
//   gnt_vld    : a grant is issued this cycle
//   gnt_side   : granted side (GNT_RD / GNT_WR)
module hawk_rr_arb2
    import hacd_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       en,
    input  logic [1:0] req,
    output logic       gnt_vld,
    output logic       gnt_side
);

    logic last_grant;

    always_comb begin
        gnt_vld  = en && (|req);
        gnt_side = GNT_RD;
        if (&req)
            gnt_side = ~last_grant;      // tie: side not served last
        else if (req[GNT_WR])
            gnt_side = GNT_WR;
    end

    // Reset to RD so the first tie goes to WR
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            last_grant <= GNT_RD;
        else if (gnt_vld)
            last_grant <= gnt_side;
    end

endmodule

// File: rtl/hawk_cpu_lkup_arb.sv
// Arbitrates read-stall and write-stall page lookups onto the single hawk
// lookup channel, one in flight at a time, and returns the translated page
// with a one-cycle allow_access pulse to the requesting side only. A
// watchdog releases the requester with an identity translation if hawk
// never answers.
//   clk, rst_n            : clock, async active-low reset
//   hawk_inactive         : blocks new grants while high
//   rd/wr_cpu_reqpkt      : requests from read/write stall blocks
//   rd/wr_hawk_cpu_ovrd_pkt : ppa + allow_access back to each stall block
//   lkup                  : hawk lookup channel (master)
//   lkup_timeout_err      : sticky watchdog-expiry flag
//   lkup_cnt, timeout_cnt : saturating completed-lookup / expiry counters
module hawk_cpu_lkup_arb
    import hacd_pkg::*;
#(
    parameter int          PPA_WIDTH      = hacd_pkg::PPA_WIDTH,
    parameter int unsigned TIMEOUT_CYCLES = 1024,
    parameter int          CNT_WIDTH      = 32
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       hawk_inactive,
    input  cpu_reqpkt_t                rd_cpu_reqpkt,
    input  cpu_reqpkt_t                wr_cpu_reqpkt,
    output hawk_cpu_ovrd_pkt_t         rd_hawk_cpu_ovrd_pkt,
    output hawk_cpu_ovrd_pkt_t         wr_hawk_cpu_ovrd_pkt,
    hawk_cpu_lkup_arb_if.master        lkup,
    output logic                       lkup_timeout_err,
    output logic [CNT_WIDTH-1:0]       lkup_cnt,
    output logic [CNT_WIDTH-1:0]       timeout_cnt
);

    hawk_lkup_arb_state_e state_q, state_d;

    lkup_req_t            req_q;
    logic                 side_q;
    logic                 hold_q;     // first IDLE cycle after RELEASE
    logic [31:0]          wd_q;
    logic [PPA_WIDTH-1:0] rd_ppa_q, wr_ppa_q;

    logic gnt_en, gnt_vld, gnt_side;
    logic rsp_hit, tmo_hit, wd_expired;

    // Read side has no zero-block write semantics
    logic unused_rd_zero;
    assign unused_rd_zero = rd_cpu_reqpkt.zeroBlkWr;

    // Requester valid is not looked at while its previous release is still
    // visible to it (RELEASE and the following IDLE cycle)
    assign gnt_en = (state_q == ST_IDLE) && !hold_q && !hawk_inactive;

    hawk_rr_arb2 u_arb (
        .clk      (clk),
        .rst_n    (rst_n),
        .en       (gnt_en),
        .req      ({wr_cpu_reqpkt.valid, rd_cpu_reqpkt.valid}),
        .gnt_vld  (gnt_vld),
        .gnt_side (gnt_side)
    );

    assign wd_expired = (TIMEOUT_CYCLES != 0) && (wd_q == 32'(TIMEOUT_CYCLES - 1));

    always_comb begin
        state_d = state_q;
        rsp_hit = 1'b0;
        tmo_hit = 1'b0;
        case (state_q)
            ST_IDLE:     if (gnt_vld) state_d = ST_REQ;
            ST_REQ:      if (lkup.lkup_req_ready) state_d = ST_WAIT_RSP;
            ST_WAIT_RSP: begin
                // A response on the expiry cycle counts as a normal response
                rsp_hit = lkup.lkup_rsp_valid;
                tmo_hit = wd_expired && !lkup.lkup_rsp_valid;
                if (rsp_hit || tmo_hit) state_d = ST_RELEASE;
            end
            ST_RELEASE:  state_d = ST_IDLE;
            default:     state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state_q <= ST_IDLE;
        else
            state_q <= state_d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            req_q            <= '0;
            side_q           <= GNT_RD;
            hold_q           <= 1'b0;
            wd_q             <= '0;
            rd_ppa_q         <= '0;
            wr_ppa_q         <= '0;
            lkup_timeout_err <= 1'b0;
            lkup_cnt         <= '0;
            timeout_cnt      <= '0;
        end else begin
            hold_q <= (state_q == ST_RELEASE);

            if (gnt_vld) begin
                side_q          <= gnt_side;
                req_q.hppa      <= (gnt_side == GNT_WR) ? wr_cpu_reqpkt.hppa : rd_cpu_reqpkt.hppa;
                req_q.is_wr     <= (gnt_side == GNT_WR);
                req_q.zeroBlkWr <= (gnt_side == GNT_WR) && wr_cpu_reqpkt.zeroBlkWr;
            end

            // Held at zero until the handshake, then counts WAIT_RSP cycles
            if (state_q == ST_REQ)
                wd_q <= '0;
            else if (state_q == ST_WAIT_RSP)
                wd_q <= wd_q + 32'd1;

            if (rsp_hit) begin
                if (side_q == GNT_WR) wr_ppa_q <= lkup.lkup_rsp_ppa;
                else                  rd_ppa_q <= lkup.lkup_rsp_ppa;
                if (!(&lkup_cnt)) lkup_cnt <= lkup_cnt + 1'b1;
            end

            // Forced release falls back to an identity translation
            if (tmo_hit) begin
                if (side_q == GNT_WR) wr_ppa_q <= req_q.hppa;
                else                  rd_ppa_q <= req_q.hppa;
                lkup_timeout_err <= 1'b1;
                if (!(&timeout_cnt)) timeout_cnt <= timeout_cnt + 1'b1;
            end
        end
    end

    assign lkup.lkup_req       = req_q;
    assign lkup.lkup_req_valid = (state_q == ST_REQ);

    assign rd_hawk_cpu_ovrd_pkt = '{ppa: rd_ppa_q,
                                    allow_access: (state_q == ST_RELEASE) && (side_q == GNT_RD)};
    assign wr_hawk_cpu_ovrd_pkt = '{ppa: wr_ppa_q,
                                    allow_access: (state_q == ST_RELEASE) && (side_q == GNT_WR)};

endmodule

// File: tb/tb_hawk_cpu_lkup_arb.sv
module tb_hawk_cpu_lkup_arb;
    import hacd_pkg::*;

    localparam int CW = 32;

    logic               clk;
    logic               rst_n;
    logic               hawk_inactive;
    cpu_reqpkt_t        rd_pkt, wr_pkt;
    hawk_cpu_ovrd_pkt_t rd_ovrd, wr_ovrd;
    logic               tmo_err;
    logic [CW-1:0]      lkup_cnt, timeout_cnt;

    int n_cmp = 0;
    int n_err = 0;

    hawk_cpu_lkup_arb_if lk ();

    hawk_cpu_lkup_arb #(
        .TIMEOUT_CYCLES (16),
        .CNT_WIDTH      (CW)
    ) dut (
        .clk                  (clk),
        .rst_n                (rst_n),
        .hawk_inactive        (hawk_inactive),
        .rd_cpu_reqpkt        (rd_pkt),
        .wr_cpu_reqpkt        (wr_pkt),
        .rd_hawk_cpu_ovrd_pkt (rd_ovrd),
        .wr_hawk_cpu_ovrd_pkt (wr_ovrd),
        .lkup                 (lk.master),
        .lkup_timeout_err     (tmo_err),
        .lkup_cnt             (lkup_cnt),
        .timeout_cnt          (timeout_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        hawk_inactive = 1'b0;
        rd_pkt = '0;
        wr_pkt = '0;
        lk.lkup_req_ready = 1'b0;
        lk.lkup_rsp_valid = 1'b0;
        lk.lkup_rsp_ppa = '0;
        #3;
        rst_n = 1'b1;
    endtask

    // Wait for a request, accept it, answer next cycle, check the release
    task automatic serve(input logic exp_wr, input logic [PPA_WIDTH-1:0] exp_hppa,
                         input logic [PPA_WIDTH-1:0] rsp, input string tag);
        int n = 0;
        while (!lk.lkup_req_valid && n < 20) begin
            tick();
            n++;
        end
        chk({tag, "_req_seen"}, 64'(lk.lkup_req_valid), 64'd1);
        chk({tag, "_is_wr"}, 64'(lk.lkup_req.is_wr), 64'(exp_wr));
        chk({tag, "_hppa"}, 64'(lk.lkup_req.hppa), 64'(exp_hppa));
        lk.lkup_req_ready = 1'b1;
        tick();
        lk.lkup_rsp_valid = 1'b1;
        lk.lkup_rsp_ppa = rsp;
        tick();
        lk.lkup_rsp_valid = 1'b0;
        if (exp_wr) begin
            chk({tag, "_allow"}, 64'(wr_ovrd.allow_access), 64'd1);
            chk({tag, "_ppa"}, 64'(wr_ovrd.ppa), 64'(rsp));
            chk({tag, "_other"}, 64'(rd_ovrd.allow_access), 64'd0);
            wr_pkt.valid = 1'b0;
        end else begin
            chk({tag, "_allow"}, 64'(rd_ovrd.allow_access), 64'd1);
            chk({tag, "_ppa"}, 64'(rd_ovrd.ppa), 64'(rsp));
            chk({tag, "_other"}, 64'(wr_ovrd.allow_access), 64'd0);
            rd_pkt.valid = 1'b0;
        end
        tick();
    endtask

    initial begin
        logic seen;
        logic stable;

        // ---- reset state ----
        rst_n = 1'b0;
        hawk_inactive = 1'b0;
        rd_pkt = '0;
        wr_pkt = '0;
        lk.lkup_req_ready = 1'b0;
        lk.lkup_rsp_valid = 1'b0;
        lk.lkup_rsp_ppa = '0;
        #22;
        chk("rst_req_valid", 64'(lk.lkup_req_valid), 64'd0);
        chk("rst_req", 64'(lk.lkup_req), 64'd0);
        chk("rst_rd_ovrd", 64'(rd_ovrd), 64'd0);
        chk("rst_wr_ovrd", 64'(wr_ovrd), 64'd0);
        chk("rst_cnts", {timeout_cnt, lkup_cnt}, 64'd0);
        chk("rst_err", 64'(tmo_err), 64'd0);
        rst_n = 1'b1;

        // ---- single WR request, response 3 cycles into WAIT_RSP ----
        wr_pkt = '{hppa: 20'h12345, valid: 1'b1, zeroBlkWr: 1'b1};
        lk.lkup_req_ready = 1'b1;
        tick();
        chk("t1_req_valid", 64'(lk.lkup_req_valid), 64'd1);
        chk("t1_hppa", 64'(lk.lkup_req.hppa), 64'h12345);
        chk("t1_is_wr", 64'(lk.lkup_req.is_wr), 64'd1);
        chk("t1_zero", 64'(lk.lkup_req.zeroBlkWr), 64'd1);
        tick();
        chk("t1_valid_drop", 64'(lk.lkup_req_valid), 64'd0);
        tick();
        tick();
        chk("t1_no_early", 64'(wr_ovrd.allow_access), 64'd0);
        lk.lkup_rsp_valid = 1'b1;
        lk.lkup_rsp_ppa = 20'h0ABCD;
        tick();
        lk.lkup_rsp_valid = 1'b0;
        chk("t1_allow", 64'(wr_ovrd.allow_access), 64'd1);
        chk("t1_ppa", 64'(wr_ovrd.ppa), 64'h0ABCD);
        chk("t1_rd_ovrd", 64'(rd_ovrd), 64'd0);
        chk("t1_lkup_cnt", 64'(lkup_cnt), 64'd1);
        wr_pkt.valid = 1'b0;
        tick();
        chk("t1_pulse_1cyc", 64'(wr_ovrd.allow_access), 64'd0);
        chk("t1_ppa_hold", 64'(wr_ovrd.ppa), 64'h0ABCD);

        // ---- ties from reset: WR, RD, WR ----
        do_reset();
        rd_pkt = '{hppa: 20'h00111, valid: 1'b1, zeroBlkWr: 1'b1};
        wr_pkt = '{hppa: 20'h00222, valid: 1'b1, zeroBlkWr: 1'b0};
        lk.lkup_req_ready = 1'b1;
        serve(1'b1, 20'h00222, 20'h000AA, "tie1");
        wr_pkt.valid = 1'b1;
        serve(1'b0, 20'h00111, 20'h000BB, "tie2");
        chk("tie2_rd_zero_ignored", 64'(lk.lkup_req.zeroBlkWr), 64'd0);
        rd_pkt.valid = 1'b1;
        serve(1'b1, 20'h00222, 20'h000CC, "tie3");
        chk("tie_rd_ppa_hold", 64'(rd_ovrd.ppa), 64'h000BB);
        chk("tie_lkup_cnt", 64'(lkup_cnt), 64'd3);
        rd_pkt.valid = 1'b0;

        // ---- backpressure: ready low 5 cycles ----
        do_reset();
        wr_pkt = '{hppa: 20'h0BEEF, valid: 1'b1, zeroBlkWr: 1'b0};
        tick();
        stable = 1'b1;
        for (int i = 0; i < 5; i++) begin
            if (!lk.lkup_req_valid || lk.lkup_req.hppa !== 20'h0BEEF) stable = 1'b0;
            tick();
        end
        chk("bp_held_stable", 64'(stable), 64'd1);
        chk("bp_still_valid", 64'(lk.lkup_req_valid), 64'd1);
        lk.lkup_req_ready = 1'b1;
        tick();
        chk("bp_to_wait", 64'(lk.lkup_req_valid), 64'd0);
        lk.lkup_rsp_valid = 1'b1;
        lk.lkup_rsp_ppa = 20'h0F00D;
        tick();
        lk.lkup_rsp_valid = 1'b0;
        chk("bp_allow", 64'(wr_ovrd.allow_access), 64'd1);
        wr_pkt.valid = 1'b0;
        tick();

        // ---- watchdog expiry, TIMEOUT_CYCLES=16 ----
        do_reset();
        rd_pkt = '{hppa: 20'h00777, valid: 1'b1, zeroBlkWr: 1'b0};
        lk.lkup_req_ready = 1'b1;
        tick();
        chk("tmo_req_valid", 64'(lk.lkup_req_valid), 64'd1);
        tick();
        for (int i = 0; i < 15; i++) tick();
        chk("tmo_not_early", 64'(rd_ovrd.allow_access), 64'd0);
        tick();
        chk("tmo_allow", 64'(rd_ovrd.allow_access), 64'd1);
        chk("tmo_ppa_identity", 64'(rd_ovrd.ppa), 64'h00777);
        chk("tmo_err", 64'(tmo_err), 64'd1);
        chk("tmo_cnt", 64'(timeout_cnt), 64'd1);
        chk("tmo_lkup_cnt", 64'(lkup_cnt), 64'd0);
        rd_pkt.valid = 1'b0;
        tick();
        chk("tmo_err_sticky", 64'(tmo_err), 64'd1);

        // ---- hawk_inactive ----
        do_reset();
        hawk_inactive = 1'b1;
        rd_pkt = '{hppa: 20'h00555, valid: 1'b1, zeroBlkWr: 1'b0};
        lk.lkup_req_ready = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (lk.lkup_req_valid) seen = 1'b1;
        end
        chk("inact_no_req", 64'(seen), 64'd0);
        hawk_inactive = 1'b0;
        tick();
        chk("inact_req_after", 64'(lk.lkup_req_valid), 64'd1);
        tick();
        hawk_inactive = 1'b1;
        tick();
        tick();
        lk.lkup_rsp_valid = 1'b1;
        lk.lkup_rsp_ppa = 20'h00042;
        tick();
        lk.lkup_rsp_valid = 1'b0;
        chk("inact_inflight_allow", 64'(rd_ovrd.allow_access), 64'd1);
        chk("inact_inflight_ppa", 64'(rd_ovrd.ppa), 64'h00042);
        rd_pkt.valid = 1'b0;
        wr_pkt = '{hppa: 20'h00999, valid: 1'b1, zeroBlkWr: 1'b0};
        seen = 1'b0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (lk.lkup_req_valid) seen = 1'b1;
        end
        chk("inact_no_new_grant", 64'(seen), 64'd0);
        wr_pkt.valid = 1'b0;
        hawk_inactive = 1'b0;
        tick();

        // ---- reset during WAIT_RSP, late response ignored ----
        do_reset();
        wr_pkt = '{hppa: 20'h00ABC, valid: 1'b1, zeroBlkWr: 1'b0};
        lk.lkup_req_ready = 1'b1;
        tick();
        tick();
        #2;
        rst_n = 1'b0;
        #1;
        chk("mrst_req_valid", 64'(lk.lkup_req_valid), 64'd0);
        chk("mrst_req", 64'(lk.lkup_req), 64'd0);
        chk("mrst_wr_ovrd", 64'(wr_ovrd), 64'd0);
        wr_pkt.valid = 1'b0;
        lk.lkup_rsp_valid = 1'b1;
        lk.lkup_rsp_ppa = 20'h00321;
        rst_n = 1'b1;
        tick();
        lk.lkup_rsp_valid = 1'b0;
        chk("mrst_late_rsp_cnt", 64'(lkup_cnt), 64'd0);
        chk("mrst_no_allow", 64'({rd_ovrd, wr_ovrd}), 64'd0);
        tick();
        chk("mrst_idle", 64'(lk.lkup_req_valid), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/hawk_cpu_lkup_arb.md
Name: hawk_cpu_lkup_arb

Overview:
- Sits between the CPU-side stall blocks (read-stall and write-stall) and the hawk translation/lookup engine.
- Each stall block emits a `cpu_reqpkt_t` and holds `valid` high until it receives `allow_access`.
- This block round-robin arbitrates between the two, issues one lookup at a time to hawk, and captures the response.
- It returns a `hawk_cpu_ovrd_pkt_t` (`ppa` + one-cycle `allow_access` pulse) to the requesting side only; a timeout watchdog forces release if hawk does not answer.

Parameters:
- PPA_WIDTH, `HACD_AXI4_ADDR_WIDTH-12, width of hppa/ppa (4KB page numbers)
- TIMEOUT_CYCLES, 1024, cycles in WAIT_RSP before forced release; 0 disables the watchdog
- CNT_WIDTH, 32, width of statistics counters

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- hawk_inactive  in  1  hawk bypass mode; block accepts no new lookups while high
- rd_cpu_reqpkt  in  cpu_reqpkt_t  read-stall lookup request (hppa, valid, zeroBlkWr ignored)
- wr_cpu_reqpkt  in  cpu_reqpkt_t  write-stall lookup request (hppa, valid, zeroBlkWr)
- rd_hawk_cpu_ovrd_pkt  out  hawk_cpu_ovrd_pkt_t  ppa/allow_access to read-stall
- wr_hawk_cpu_ovrd_pkt  out  hawk_cpu_ovrd_pkt_t  ppa/allow_access to write-stall
- lkup_req  out  lkup_req_t  {hppa, is_wr, zeroBlkWr} to hawk
- lkup_req_valid  out  1  lookup request valid
- lkup_req_ready  in  1  hawk accepts request
- lkup_rsp_valid  in  1  hawk response valid (single-cycle)
- lkup_rsp_ppa  in  PPA_WIDTH  translated page
- lkup_timeout_err  out  1  sticky; set on any watchdog expiry
- lkup_cnt  out  CNT_WIDTH  completed lookups (saturating)
- timeout_cnt  out  CNT_WIDTH  watchdog expiries (saturating)

Behaviour:
- Reset values:
  - all outputs 0, state IDLE
  - last_grant = RD, so WR wins the first tie
  - ppa regs 0, counters 0, err 0
- States:
  - IDLE:
    - if !hawk_inactive and any valid: grant by round-robin (both valid → side != last_grant).
    - Latch hppa/is_wr/zeroBlkWr into lkup_req and update last_grant.
    - Assert lkup_req_valid next cycle; → REQ.
  - REQ:
    - lkup_req_valid=1, lkup_req stable until lkup_req_ready.
    - On valid&ready: drop valid, clear watchdog; → WAIT_RSP.
  - WAIT_RSP:
    - On lkup_rsp_valid: load granted side's ppa reg with lkup_rsp_ppa, increment lkup_cnt; → RELEASE.
    - Watchdog reaching TIMEOUT_CYCLES-1: ppa ← latched hppa (identity), set lkup_timeout_err, increment timeout_cnt; → RELEASE.
    - A response arriving in the same cycle as watchdog expiry wins; it is treated as a normal response.
  - RELEASE:
    - Granted side's allow_access=1 for exactly one cycle, with ppa valid the same cycle.
    - → IDLE.
- ppa regs hold their value until the next grant to that same side; the requester samples ppa the cycle after the pulse.
- Requester valid is not re-sampled in RELEASE or in the first IDLE cycle after it. The requester drops valid combinationally on allow_access, so no double grant occurs.
- Minimum latency with ready and response in consecutive cycles: valid seen → allow_access = 4 cycles (IDLE→REQ→WAIT_RSP→RELEASE).
- Non-granted side's allow_access stays 0; its valid may stay high indefinitely without effect.
- hawk_inactive rising mid-transaction: the in-flight lookup completes normally; no new grant while high.
- lkup_rsp_valid outside WAIT_RSP: ignored, and has no effect on counters.
- Counters saturate at all-ones.
- Reset mid-operation: immediate return to IDLE, all pulses/valids deasserted.

Decomposition:
- hacd_pkg holds:
  - existing cpu_reqpkt_t and hawk_cpu_ovrd_pkt_t
  - new lkup_req_t {hppa[PPA_WIDTH], is_wr, zeroBlkWr}
  - state enum hawk_lkup_arb_state_e
  - RD/WR grant encoding constants
- One sub-module: hawk_rr_arb2 (2-requester round-robin, last_grant register, grant-enable input).

Test Plan:
- Single WR request: wr hppa=0x12345, ready=1, rsp ppa=0x0ABCD after 3 cycles → lkup_req.hppa=0x12345, is_wr=1. wr allow_access pulses 1 cycle with ppa=0x0ABCD; rd_ovrd stays 0; lkup_cnt=1.
- Simultaneous RD/WR valid from reset: WR granted first. After release, RD granted; the next tie goes to WR. Grant order WR,RD,WR over 3 tie rounds.
- Backpressure: lkup_req_ready low 5 cycles → lkup_req_valid held, hppa stable all 5 cycles, then WAIT_RSP.
- Timeout with TIMEOUT_CYCLES=16 and no response: rd hppa=0x00777 → allow_access after 16 WAIT_RSP cycles with ppa=0x00777; lkup_timeout_err=1; timeout_cnt=1.
- hawk_inactive=1 with rd valid → no lkup_req_valid ever. Asserting hawk_inactive during WAIT_RSP → response 0x00042 still delivered to the granted side.
- rst_n low during WAIT_RSP → outputs 0 asynchronously, state IDLE. A late lkup_rsp_valid after reset is ignored and lkup_cnt=0.
